// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the fifo_rd_stream read-side drain engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned STAT_W     = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words out of the drain engine.
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry skid storage with 1-bit wrapping head/tail pointers; occupancy lives in the top.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (clear) begin
      // Contents are left in place; only the pointers matter once occupancy is zero.
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port drain engine: pops the FIFO, hides its 1-cycle read latency, streams words out.
// Optional FIFO_RD_STATS_EN adds saturating transfer/stall counters.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_data,
  output logic                  fifo_r_en,
  fifo_rd_stream_if.master      out_if
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_words,
  output logic [STAT_W-1:0]     stat_stalls
`endif
);

  occ_e       cnt_q, cnt_d;
  logic       inflight_q;
  logic       discard_q, discard_d;
  logic       push;
  logic       pop;
  logic [2:0] credit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= S_EMPTY;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= fifo_r_en;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    push      = inflight_q & ~discard_q;
    pop       = out_if.out_valid & out_if.out_ready;
    // Slots committed after this edge: held words plus the one returning, minus the one leaving.
    credit    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_r_en = ~flush & ~fifo_empty & (credit < 3'd2);
    discard_d = flush & inflight_q;
    cnt_d     = cnt_q;
    if (flush) begin
      cnt_d = S_EMPTY;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt_d = (cnt_q == S_EMPTY) ? S_ONE : S_TWO;
        2'b01:   cnt_d = (cnt_q == S_TWO) ? S_ONE : S_EMPTY;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign out_if.out_valid = (cnt_q != S_EMPTY);

  fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata (fifo_data),
    .rdata (out_if.out_data)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (cnt_q == S_TWO)));

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] stat_words_q;
  logic [STAT_W-1:0] stat_stalls_q;

  // Cleared by reset only; flush does not touch the statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (pop) stat_words_q <= sat_inc(stat_words_q);
      if (out_if.out_valid && !out_if.out_ready) stat_stalls_q <= sat_inc(stat_stalls_q);
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
